uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the byte width stored per entry.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, meaning log2 of FIFO depth (depth 16).
REQ-003 The block SHALL have port clock, input, 1, meaning the board clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port rx_done, input, 1, meaning the receiver byte-complete flag, a level that may stay high for many clocks.
REQ-006 The block SHALL have port d_in, input, DATA_WIDTH, meaning the received byte, stable while rx_done is high.
REQ-007 The block SHALL have port rd, input, 1, meaning the consumer pop strobe, one entry per high clock.
REQ-008 The block SHALL have port d_out, output, DATA_WIDTH, meaning the head entry in first-word-fall-through mode.
REQ-009 The block SHALL have port empty, output, 1, meaning the FIFO holds 0 entries.
REQ-010 The block SHALL have port full, output, 1, meaning the FIFO holds 2^ADDR_WIDTH entries.
REQ-011 The block SHALL have port count, output, ADDR_WIDTH+1, meaning the current occupancy, 0..2^ADDR_WIDTH.
REQ-012 The block SHALL have port overflow, output, 1, meaning the sticky flag for a dropped byte.
REQ-013 The block SHALL have port clear_ovf, input, 1, meaning a synchronous clear of overflow.

Function
REQ-014 The block SHALL register rx_done into rx_done_q each clock; push = rx_done & ~rx_done_q, so each high level of rx_done generates exactly one push regardless of its duration.
REQ-015 On push with full=0, the block SHALL write d_in to mem[wr_ptr] and increment wr_ptr modulo 2^ADDR_WIDTH.
REQ-016 On push with full=1 and rd=0, the block SHALL drop the byte, leave pointers and count unchanged, and set overflow to 1 on the next edge.
REQ-017 On rd=1 with empty=0, the block SHALL increment rd_ptr modulo 2^ADDR_WIDTH; rd=1 with empty=1 SHALL be ignored with no state change.
REQ-018 d_out SHALL equal mem[rd_ptr] combinationally whenever empty=0; its value while empty=1 is don't-care.
REQ-019 On simultaneous push and valid pop, both SHALL complete, count SHALL stay unchanged, and when full=1 no overflow SHALL occur.
REQ-020 On simultaneous push and rd with empty=1, only the write SHALL take effect and count SHALL become 1.
REQ-021 count SHALL increment on push only, decrement on pop only, and stay unchanged on both or neither.
REQ-022 empty SHALL be (count==0) and full SHALL be (count==2^ADDR_WIDTH); both SHALL be registered or derived from registered count with no added latency.
REQ-023 Latency SHALL be as follows: the byte is visible on d_out and empty falls one clock after the rx_done rising edge is sampled, i.e. two edges after rx_done rises.
REQ-024 clear_ovf=1 SHALL clear overflow; if a drop occurs in the same cycle, overflow SHALL remain 1 (set wins).
REQ-025 Pointer wrap from 2^ADDR_WIDTH-1 to 0 SHALL be seamless with no lost or duplicated entries.

Reset
REQ-026 While reset=1, the block SHALL force wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, and overflow=0 asynchronously.
REQ-027 While reset=1, rx_done_q SHALL be forced to 1, so rx_done already high at reset release generates no push.
REQ-028 Memory contents need not be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries, and the first push after release SHALL land at mem[0].

Verification
REQ-030 The bench SHALL cover this case: rx_done held high 50 clocks with d_in=0xA5 -> count=1, d_out=0xA5, empty=0; a single rd -> empty=1, count=0.
REQ-031 The bench SHALL cover this case: push 16 bytes 0x00..0x0F -> full=1, count=16; 17th push 0xFF -> overflow=1, count=16; popping all yields 0x00..0x0F in order.
REQ-032 The bench SHALL cover this case: with full=1, push 0x55 and rd in the same clock -> count stays 16, overflow=0, and 0x55 is read last.
REQ-033 The bench SHALL cover this case: with empty=1, rd=1 for 3 clocks -> count=0, rd_ptr unchanged; a subsequent push 0x3C -> d_out=0x3C.
REQ-034 The bench SHALL cover this case: 40 push/pop pairs of an incrementing pattern -> pointers wrap twice and data matches with no loss.
REQ-035 The bench SHALL cover this case: reset pulsed with count=5 and rx_done=1 -> count=0, empty=1, and no push after release until rx_done falls and rises again.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : Receive-side FIFO for a UART. Turns each rising level of the
//            receiver's byte-complete flag into exactly one write, buffers
//            bytes in a circular RAM and presents the head entry
//            combinationally (first-word-fall-through). Keeps a sticky
//            overflow flag for bytes dropped while full.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  rd,
  input  logic                  clear_ovf,
  output logic [DATA_WIDTH-1:0] d_out,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_one   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

  // Edge detector and pipelined write request. The byte is captured together
  // with the detected edge, so the write lands on the following clock and the
  // entry becomes visible two edges after rx_done rises.
  logic                  rx_done_q, rx_done_d;
  logic                  push_q, push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  pop;
  logic                  wr_en;
  logic                  drop;

  // Status flags come straight from the registered occupancy.
  assign empty    = (count_q == '0);
  assign full     = (count_q == c_depth);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign d_out    = mem_q[rd_ptr_q];

  // Detect the rising level of rx_done and stage the byte for writing.
  always_comb begin
    rx_done_d = rx_done;
    push_d    = rx_done & ~rx_done_q;
    data_d    = d_in;
  end

  // Decide pop/write/drop; a pop in the same cycle frees the slot a full
  // FIFO needs, so the write proceeds instead of being dropped.
  always_comb begin
    pop   = rd & ~empty;
    wr_en = push_q & (~full | pop);
    drop  = push_q & full & ~pop;
  end

  // Next-state for pointers, occupancy and the sticky overflow (set wins).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (pop)   rd_ptr_d = rd_ptr_q + c_ptr_one;
    if (wr_en && !pop)      count_d = count_q + c_one;
    else if (pop && !wr_en) count_d = count_q - c_one;
    if (drop)           overflow_d = 1'b1;
    else if (clear_ovf) overflow_d = 1'b0;
  end

  // Control state; rx_done_q resets high so a level already present at
  // reset release is not mistaken for a new byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_done_q  <= 1'b1;
      push_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rx_done_q  <= rx_done_d;
      push_q     <= push_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Staged data byte; no reset needed since it is only used with push_q.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Directed self-checking bench for uart_rx_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic       clock;
  logic       reset;
  logic       rx_done;
  logic [7:0] d_in;
  logic       rd;
  logic       clear_ovf;
  logic [7:0] d_out;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;

  int checks;
  int errors;

  uart_rx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_done   (rx_done),
    .d_in      (d_in),
    .rd        (rd),
    .clear_ovf (clear_ovf),
    .d_out     (d_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus helper: one rx_done pulse, returns once the byte is visible.
  task automatic push_byte(input logic [7:0] b);
    @(negedge clock);
    rx_done = 1'b1;
    d_in    = b;
    @(negedge clock);
    rx_done = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", full); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_release_count: got %0d expected 0", count); end
  endtask

  // Long rx_done level yields exactly one entry; two-edge latency.
  task automatic test_hold();
    @(negedge clock);
    rx_done = 1'b1;
    d_in    = 8'hA5;
    @(negedge clock);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_latency_empty: got %b expected 1", empty); end
    @(negedge clock);
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL hold_empty: got %b expected 0", empty); end
    checks++; if (d_out !== 8'hA5) begin errors++; $display("FAIL hold_dout: got %h expected a5", d_out); end
    repeat (48) @(negedge clock);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL hold_count: got %0d expected 1", count); end
    rx_done = 1'b0;
    @(negedge clock);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_pop_empty: got %b expected 1", empty); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL hold_pop_count: got %0d expected 0", count); end
  endtask

  // Fill to 16, overflow on 17th, clear, set-wins, then drain in order.
  task automatic test_full();
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d expected 16", count); end
    push_byte(8'hFF);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", count); end
    clear_ovf = 1'b1;
    @(negedge clock);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    // Drop and clear together: the drop must win.
    rx_done   = 1'b1;
    d_in      = 8'hEE;
    clear_ovf = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
    @(negedge clock);
    clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      checks++; if (d_out !== 8'(i)) begin errors++; $display("FAIL full_drain[%0d]: got %h expected %h", i, d_out, 8'(i)); end
      rd = 1'b1;
      @(negedge clock);
      rd = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b expected 1", empty); end
    clear_ovf = 1'b1;
    @(negedge clock);
    clear_ovf = 1'b0;
  endtask

  // Push and pop together while full: no drop, newest byte comes out last.
  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    @(negedge clock);
    rx_done = 1'b1;
    d_in    = 8'h55;
    @(negedge clock);
    rx_done = 1'b0;
    rd      = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    @(negedge clock);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL simul_count: got %0d expected 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_ovf: got %b expected 0", overflow); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i < 15) ? 8'h11 + 8'(i) : 8'h55;
      @(negedge clock);
      checks++; if (d_out !== exp) begin errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, d_out, exp); end
      rd = 1'b1;
      @(negedge clock);
      rd = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b expected 1", empty); end
  endtask

  // Reads on an empty FIFO are ignored; a push with rd high writes only.
  task automatic test_empty_rd();
    @(negedge clock);
    rd = 1'b1;
    repeat (3) @(negedge clock);
    rd = 1'b0;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL emptyrd_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL emptyrd_empty: got %b expected 1", empty); end
    push_byte(8'h3C);
    checks++; if (d_out !== 8'h3C) begin errors++; $display("FAIL emptyrd_dout: got %h expected 3c", d_out); end
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    // Push while rd is held on an empty FIFO.
    rx_done = 1'b1;
    d_in    = 8'h6B;
    rd      = 1'b1;
    @(negedge clock);
    rx_done = 1'b0;
    @(negedge clock);
    rd = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL emptyrd_push_count: got %0d expected 1", count); end
    checks++; if (d_out !== 8'h6B) begin errors++; $display("FAIL emptyrd_push_dout: got %h expected 6b", d_out); end
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  // Simultaneous push and pop on a partially filled FIFO keeps count.
  task automatic test_back_to_back();
    push_byte(8'hB0);
    push_byte(8'hB1);
    rx_done = 1'b1;
    d_in    = 8'hB2;
    @(negedge clock);
    rx_done = 1'b0;
    rd      = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", count); end
    checks++; if (d_out !== 8'hB1) begin errors++; $display("FAIL b2b_head: got %h expected b1", d_out); end
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    checks++; if (d_out !== 8'hB2) begin errors++; $display("FAIL b2b_tail: got %h expected b2", d_out); end
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty); end
  endtask

  // 40 push/pop pairs drive both pointers around the ring more than twice.
  task automatic test_wrap();
    for (int k = 0; k < 40; k++) begin
      push_byte(8'h80 + 8'(k));
      checks++; if (d_out !== 8'h80 + 8'(k)) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", k, d_out, 8'h80 + 8'(k)); end
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 1", k, count); end
      rd = 1'b1;
      @(negedge clock);
      rd = 1'b0;
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  // Reset mid-operation with rx_done high: contents lost, no spurious push.
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 5", count); end
    @(negedge clock);
    rx_done = 1'b1;
    d_in    = 8'hDD;
    reset   = 1'b1;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_async_count: got %0d expected 0", count); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty: got %b expected 1", empty); end
    rx_done = 1'b0;
    push_byte(8'h77);
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL rmid_push_count: got %0d expected 1", count); end
    checks++; if (d_out !== 8'h77) begin errors++; $display("FAIL rmid_push_dout: got %h expected 77", d_out); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    rx_done   = 1'b0;
    d_in      = 8'h00;
    rd        = 1'b0;
    clear_ovf = 1'b0;
    test_reset();
    test_hold();
    test_full();
    test_full_simul();
    test_empty_rd();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
